// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for the front-end redirect controller: opcodes, FSM states, branch FIFO entry.
package branch_redirect_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OPC_W  = 7;

  localparam logic [OPC_W-1:0] B_TYPE = 7'b1100011;
  localparam logic [OPC_W-1:0] J_TYPE = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    FLUSH = 2'd2
  } redir_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] target;
  } br_entry_t;

endpackage

// File: rtl/addr_calc.sv
// Per-lane target computation and control-flow classification.
module addr_calc
  import branch_redirect_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] imm,
  output logic [ADDR_W-1:0] target_c,
  output logic              is_branch_c,
  output logic              is_jump_c
);

  // Target is PC-relative; the immediate arrives already sign-extended.
  assign target_c    = pc + imm;
  assign is_branch_c = (opcode == B_TYPE);
  assign is_jump_c   = (opcode == J_TYPE);

endmodule

// File: rtl/br_tag_fifo.sv
// In-order FIFO of unresolved branch targets; 2 pushes, 1 pop and a full clear per cycle.
module br_tag_fifo
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push0,
  input  logic             push1,
  input  br_entry_t        din0,
  input  br_entry_t        din1,
  input  logic             pop,
  input  logic             clr,
  output br_entry_t        head_c,
  output logic [TAG_W-1:0] head_tag,
  output logic [TAG_W-1:0] tail_tag,
  output logic [TAG_W:0]   free_cnt_c,
  output logic             full_c,
  output logic             empty_c
);

  br_entry_t        mem [DEPTH];
  logic [TAG_W:0]   count;
  logic [TAG_W-1:0] wr1_idx;

  // Lane1 lands behind lane0 when both push in the same cycle.
  assign wr1_idx = tail_tag + TAG_W'(push0);

  // Entry storage; no reset needed since count gates validity.
  always_ff @(posedge clk) begin
    if (push0) mem[tail_tag] <= din0;
    if (push1) mem[wr1_idx]  <= din1;
  end

  // Pointer and occupancy update; clear discards everything and restarts tags at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_tag <= '0;
      tail_tag <= '0;
      count    <= '0;
    end else if (clr) begin
      head_tag <= '0;
      tail_tag <= '0;
      count    <= '0;
    end else begin
      tail_tag <= tail_tag + TAG_W'(push0) + TAG_W'(push1);
      head_tag <= head_tag + TAG_W'(pop);
      count    <= count + (TAG_W+1)'(push0) + (TAG_W+1)'(push1) - (TAG_W+1)'(pop);
    end
  end

  assign head_c     = mem[head_tag];
  assign free_cnt_c = (TAG_W+1)'(DEPTH) - count;
  assign full_c     = (count == (TAG_W+1)'(DEPTH));
  assign empty_c    = (count == '0);

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Dual-lane redirect sequencer: branch tracking, jump/taken-branch redirect and flush.
// Optional BR_STATS_EN adds saturating taken / not-taken / jump counters.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned BR_DEPTH = 4,
  parameter int unsigned TAG_W    = $clog2(BR_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             dec_valid,
  input  logic [1:0][OPC_W-1:0]  dec_opcode,
  input  logic [1:0][ADDR_W-1:0] dec_pc,
  input  logic [1:0][ADDR_W-1:0] dec_imm,
  output logic                   dec_stall,
  output logic                   dec_kill1,
  output logic [1:0][TAG_W-1:0]  br_tag,
  input  logic                   res_valid,
  input  logic [TAG_W-1:0]       res_tag,
  input  logic                   res_taken,
  output logic                   res_err,
  output logic                   redir_valid,
  output logic [ADDR_W-1:0]      redir_addr,
  input  logic                   redir_ready,
  output logic                   flush
`ifdef BR_STATS_EN
  ,
  output logic [31:0]            stat_br_taken,
  output logic [31:0]            stat_br_nt,
  output logic [31:0]            stat_jump
`endif
);

  redir_state_t           state, state_nxt;
  logic [ADDR_W-1:0]      addr_nxt;
  logic [1:0][ADDR_W-1:0] tgt;
  logic [1:0]             is_br, is_j;
  logic                   lane_b0, lane_b1, lane_j0, lane_j1;
  logic                   res_ok, res_tk, res_nt;
  logic [1:0]             br_need;
  logic                   cap_stall, accept, push0, push1, jmp;
  br_entry_t              fifo_head;
  logic [TAG_W-1:0]       head_tag, tail_tag;
  logic [TAG_W:0]         fifo_free;
  logic                   fifo_full, fifo_empty;

  // One target/classifier per decode lane.
  for (genvar i = 0; i < 2; i++) begin : g_lane
    addr_calc u_calc (
      .opcode      (dec_opcode[i]),
      .pc          (dec_pc[i]),
      .imm         (dec_imm[i]),
      .target_c    (tgt[i]),
      .is_branch_c (is_br[i]),
      .is_jump_c   (is_j[i])
    );
  end

  br_tag_fifo #(.DEPTH(BR_DEPTH), .TAG_W(TAG_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push0      (push0),
    .push1      (push1),
    .din0       (br_entry_t'{target: tgt[0]}),
    .din1       (br_entry_t'{target: tgt[1]}),
    .pop        (res_nt),
    .clr        (res_tk),
    .head_c     (fifo_head),
    .head_tag   (head_tag),
    .tail_tag   (tail_tag),
    .free_cnt_c (fifo_free),
    .full_c     (fifo_full),
    .empty_c    (fifo_empty)
  );

  // Lane1 is dead behind a lane0 jump, so it neither enqueues nor redirects.
  assign lane_j0 = dec_valid[0] & is_j[0];
  assign lane_b0 = dec_valid[0] & is_br[0];
  assign lane_j1 = dec_valid[1] & is_j[1] & ~lane_j0;
  assign lane_b1 = dec_valid[1] & is_br[1] & ~lane_j0;

  // Resolutions must arrive in order; anything else is flagged and ignored.
  assign res_ok  = res_valid & ~fifo_empty & (res_tag == head_tag);
  assign res_tk  = res_ok & res_taken;
  assign res_nt  = res_ok & ~res_taken;
  assign res_err = res_valid & ~res_ok;

  // All-or-nothing lane acceptance; a taken resolution outranks any decode activity.
  assign br_need   = {1'b0, lane_b0} + {1'b0, lane_b1};
  assign cap_stall = fifo_full ? (br_need != 2'd0) : ((TAG_W+1)'(br_need) > fifo_free);
  assign dec_stall = (state != IDLE) | cap_stall | res_tk;
  assign accept    = ~dec_stall;
  assign push0     = accept & lane_b0;
  assign push1     = accept & lane_b1;
  assign jmp       = accept & (lane_j0 | lane_j1);
  assign dec_kill1 = accept & lane_j0;
  assign br_tag    = {tail_tag + TAG_W'(push0), tail_tag};

  // State and redirect target registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      redir_addr <= '0;
    end else begin
      state      <= state_nxt;
      redir_addr <= addr_nxt;
    end
  end

  // Next state; an accepted taken resolution re-arms REDIR from any state with the branch target.
  always_comb begin
    state_nxt = state;
    addr_nxt  = redir_addr;
    case (state)
      IDLE: begin
        if (jmp) begin
          state_nxt = REDIR;
          addr_nxt  = lane_j0 ? tgt[0] : tgt[1];
        end
      end
      REDIR:   if (redir_ready) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (res_tk) begin
      state_nxt = REDIR;
      addr_nxt  = fifo_head.target;
    end
  end

  assign redir_valid = (state == REDIR);
  assign flush       = (state == FLUSH);

`ifdef BR_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_taken <= '0;
      stat_br_nt    <= '0;
      stat_jump     <= '0;
    end else begin
      if (res_tk && (stat_br_taken != '1)) stat_br_taken <= stat_br_taken + 32'd1;
      if (res_nt && (stat_br_nt != '1))    stat_br_nt    <= stat_br_nt + 32'd1;
      if (jmp && (state == IDLE) && !res_tk && (stat_jump != '1)) stat_jump <= stat_jump + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed and randomized bench for branch_redirect_ctrl against a queue-based reference model.
module tb_branch_redirect_ctrl;

  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_J = 7'b1101111;
  localparam logic [6:0] OP_X = 7'b0010011;
  localparam int DEPTH = 4;

  logic             clk, rst_n;
  logic [1:0]       dec_valid;
  logic [1:0][6:0]  dec_opcode;
  logic [1:0][31:0] dec_pc, dec_imm;
  logic             dec_stall, dec_kill1;
  logic [1:0][1:0]  br_tag;
  logic             res_valid, res_taken, res_err;
  logic [1:0]       res_tag;
  logic             redir_valid, redir_ready, flush;
  logic [31:0]      redir_addr;
`ifdef BR_STATS_EN
  logic [31:0]      stat_br_taken, stat_br_nt, stat_jump;
`endif

  branch_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_opcode(dec_opcode), .dec_pc(dec_pc), .dec_imm(dec_imm),
    .dec_stall(dec_stall), .dec_kill1(dec_kill1), .br_tag(br_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken), .res_err(res_err),
    .redir_valid(redir_valid), .redir_addr(redir_addr), .redir_ready(redir_ready), .flush(flush)
`ifdef BR_STATS_EN
    , .stat_br_taken(stat_br_taken), .stat_br_nt(stat_br_nt), .stat_jump(stat_jump)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending branch targets in program order plus redirect bookkeeping.
  logic [31:0] q[$];
  int          m_head, m_tail;
  bit          m_redir, m_flush;
  logic [31:0] m_addr;
  int          st_tk, st_nt, st_j;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_head = 0; m_tail = 0; m_redir = 0; m_flush = 0; m_addr = 32'h0;
    st_tk = 0; st_nt = 0; st_j = 0;
  endtask

  task automatic idle_in();
    dec_valid = 2'b00; dec_opcode = '0; dec_pc = '0; dec_imm = '0;
    res_valid = 1'b0; res_tag = 2'd0; res_taken = 1'b0; redir_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    #2;
    chk("rst_redir_valid", 32'(redir_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_dec_stall", 32'(dec_stall), 32'd0);
    chk("rst_br_tag", 32'(br_tag), 32'd0);
    chk("rst_redir_addr", redir_addr, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One clock: predict from current inputs, compare mid-cycle, then advance the model.
  task automatic cyc();
    bit b0, b1, j0, j1, rok, tk, stall, acc;
    int need;
    logic [31:0] t0, t1;
    t0 = dec_pc[0] + dec_imm[0];
    t1 = dec_pc[1] + dec_imm[1];
    j0 = dec_valid[0] && dec_opcode[0] == OP_J;
    b0 = dec_valid[0] && dec_opcode[0] == OP_B;
    j1 = dec_valid[1] && dec_opcode[1] == OP_J && !j0;
    b1 = dec_valid[1] && dec_opcode[1] == OP_B && !j0;
    rok = res_valid && q.size() > 0 && int'(res_tag) == m_head;
    tk = rok && res_taken;
    need = int'(b0) + int'(b1);
    stall = m_redir || m_flush || need > DEPTH - q.size() || tk;
    acc = !stall;
    @(negedge clk);
    chk("dec_stall", 32'(dec_stall), 32'(stall));
    chk("dec_kill1", 32'(dec_kill1), 32'(acc && j0));
    chk("res_err", 32'(res_err), 32'(res_valid && !rok));
    chk("redir_valid", 32'(redir_valid), 32'(m_redir));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("redir_addr", redir_addr, m_addr);
    if (acc && b0) chk("br_tag0", 32'(br_tag[0]), 32'(m_tail));
    if (acc && b1) chk("br_tag1", 32'(br_tag[1]), 32'((m_tail + int'(b0)) % DEPTH));
`ifdef BR_STATS_EN
    chk("stat_br_taken", stat_br_taken, 32'(st_tk));
    chk("stat_br_nt", stat_br_nt, 32'(st_nt));
    chk("stat_jump", stat_jump, 32'(st_j));
`endif
    if (tk) begin
      m_addr = q[0];
      q.delete();
      m_head = 0; m_tail = 0;
      m_redir = 1; m_flush = 0;
      st_tk++;
    end else begin
      if (rok) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % DEPTH;
        st_nt++;
      end
      if (m_redir) begin
        if (redir_ready) begin m_redir = 0; m_flush = 1; end
      end else if (m_flush) begin
        m_flush = 0;
      end else if (acc) begin
        if (b0) begin q.push_back(t0); m_tail = (m_tail + 1) % DEPTH; end
        if (b1) begin q.push_back(t1); m_tail = (m_tail + 1) % DEPTH; end
        if (j0 || j1) begin m_redir = 1; m_addr = j0 ? t0 : t1; st_j++; end
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [6:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    return (r < 4) ? OP_B : (r < 6) ? OP_J : OP_X;
  endfunction

  initial begin
    rst_n = 1'b0;
    do_reset();

    // Lane0 jump squashes lane1 branch; redirect held until fetch accepts, then one flush cycle.
    idle_in();
    dec_valid = 2'b11;
    dec_opcode[0] = OP_J; dec_pc[0] = 32'h100; dec_imm[0] = 32'h40;
    dec_opcode[1] = OP_B; dec_pc[1] = 32'h104; dec_imm[1] = 32'h20;
    #2 chk("t2_kill1", 32'(dec_kill1), 32'd1);
    cyc();
    chk("t2_addr", redir_addr, 32'h140);
    chk("t2_rv", 32'(redir_valid), 32'd1);
    idle_in(); cyc(); cyc();
    redir_ready = 1'b1; cyc();
    chk("t2_flush", 32'(flush), 32'd1);
    idle_in(); cyc();
    chk("t2_flush_done", 32'(flush), 32'd0);
    chk("t2_idle", 32'(redir_valid), 32'd0);
    res_valid = 1'b1; res_tag = 2'd0;
    #2 chk("t2_fifo_empty", 32'(res_err), 32'd1);
    cyc();

    // Asynchronous reset while a redirect is pending.
    idle_in();
    dec_valid = 2'b01; dec_opcode[0] = OP_J; dec_pc[0] = 32'h80; dec_imm[0] = 32'h10;
    cyc();
    chk("t1_in_redir", 32'(redir_valid), 32'd1);
    do_reset();

    // Fill all four entries, stall on the fifth, free one with a not-taken resolution.
    idle_in();
    dec_valid = 2'b11;
    dec_opcode[0] = OP_B; dec_opcode[1] = OP_B;
    dec_pc[0] = 32'h400; dec_pc[1] = 32'h404; dec_imm[0] = 32'h8; dec_imm[1] = 32'hC;
    cyc(); cyc();
    dec_valid = 2'b01;
    #2 chk("t3_full_stall", 32'(dec_stall), 32'd1);
    cyc();
    res_valid = 1'b1; res_tag = 2'd0; res_taken = 1'b0;
    cyc();
    res_valid = 1'b0;
    #2 chk("t3_stall_drop", 32'(dec_stall), 32'd0);
    cyc();

    // Taken resolution redirects to the branch target and empties the FIFO.
    do_reset();
    dec_valid = 2'b01; dec_opcode[0] = OP_B; dec_pc[0] = 32'h200; dec_imm[0] = 32'hFFFF_FFF8;
    cyc();
    idle_in(); res_valid = 1'b1; res_tag = 2'd0; res_taken = 1'b1;
    #2 chk("t4_stall", 32'(dec_stall), 32'd1);
    cyc();
    chk("t4_addr", redir_addr, 32'h1F8);
    idle_in(); redir_ready = 1'b1; cyc();
    idle_in(); cyc();
    res_valid = 1'b1; res_tag = 2'd0; cyc();

    // Taken resolution beats a same-cycle decode jump.
    do_reset();
    dec_valid = 2'b01; dec_opcode[0] = OP_B; dec_pc[0] = 32'h2F0; dec_imm[0] = 32'h10;
    cyc();
    dec_opcode[0] = OP_J; dec_pc[0] = 32'h480; dec_imm[0] = 32'h80;
    res_valid = 1'b1; res_tag = 2'd0; res_taken = 1'b1;
    #2 chk("t5_no_kill", 32'(dec_kill1), 32'd0);
    cyc();
    chk("t5_addr", redir_addr, 32'h300);
    idle_in(); redir_ready = 1'b1; cyc();
    idle_in(); cyc();

    // Out-of-order tag is rejected; only the accepted taken counts.
    do_reset();
    dec_valid = 2'b01; dec_opcode[0] = OP_B; dec_pc[0] = 32'h600; dec_imm[0] = 32'h20;
    cyc();
    idle_in(); res_valid = 1'b1; res_tag = 2'd2; res_taken = 1'b1;
    #2 chk("t6_err", 32'(res_err), 32'd1);
    cyc();
    chk("t6_no_redir", 32'(redir_valid), 32'd0);
`ifdef BR_STATS_EN
    chk("t6_stat_hold", stat_br_taken, 32'd0);
`endif
    res_tag = 2'd0; cyc();
    chk("t6_addr", redir_addr, 32'h620);
`ifdef BR_STATS_EN
    chk("t6_stat_inc", stat_br_taken, 32'd1);
`endif
    idle_in(); redir_ready = 1'b1; cyc();
    idle_in(); cyc();

    // Lane0 branch + lane1 jump, then fetch accept coinciding with an overriding taken resolution.
    do_reset();
    dec_valid = 2'b11;
    dec_opcode[0] = OP_B; dec_pc[0] = 32'h700; dec_imm[0] = 32'h40;
    dec_opcode[1] = OP_J; dec_pc[1] = 32'h704; dec_imm[1] = 32'h100;
    cyc();
    chk("t7_jaddr", redir_addr, 32'h804);
    idle_in(); redir_ready = 1'b1; res_valid = 1'b1; res_tag = 2'd0; res_taken = 1'b1;
    cyc();
    chk("t7_stay_redir", 32'(redir_valid), 32'd1);
    chk("t7_new_addr", redir_addr, 32'h740);
    idle_in(); redir_ready = 1'b1; cyc();
    idle_in(); cyc();

    // Random traffic with occasional mid-run resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      dec_valid     = 2'($urandom_range(0, 3));
      dec_opcode[0] = rand_op();
      dec_opcode[1] = rand_op();
      dec_pc[0]     = 32'($urandom) & 32'hFFFF_FFFC;
      dec_pc[1]     = dec_pc[0] + 32'd4;
      dec_imm[0]    = 32'($urandom_range(0, 255)) - 32'd128;
      dec_imm[1]    = 32'($urandom_range(0, 255)) - 32'd128;
      res_valid     = ($urandom_range(0, 99) < 35);
      res_tag       = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_head);
      res_taken     = ($urandom_range(0, 99) < 30);
      redir_ready   = ($urandom_range(0, 1) == 1);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
